// File: rtl/fetch_pair_buffer.sv
// fetch_pair_buffer: issues dual-address instruction fetches and queues returned pairs in order for decode
module fetch_pair_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF1,
  input  logic [31:0] pcF2,
  input  logic        pc_valid,
  output logic        pc_hold,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr_A,
  output logic [31:0] imem_req_addr_B,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_instr_A,
  input  logic [31:0] imem_resp_instr_B,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc_A,
  output logic [31:0] dec_pc_B,
  output logic [31:0] dec_instr_A,
  output logic [31:0] dec_instr_B
);
  logic [DEPTH-1:0] alloc_q, alloc_d, filled_q, filled_d;
  logic [31:0]      pca_q[DEPTH], pca_d[DEPTH], pcb_q[DEPTH], pcb_d[DEPTH];
  logic [31:0]      ia_q[DEPTH], ia_d[DEPTH], ib_q[DEPTH], ib_d[DEPTH];
  logic [PTR_W-1:0] aptr_q, aptr_d, fptr_q, fptr_d, hptr_q, hptr_d;
  logic [PTR_W:0]   occ_q, occ_d, drop_q, drop_d, unfilled, drop_sum;
  logic             accept, fill, pop;
  assign imem_req_addr_A = pcF1;
  assign imem_req_addr_B = pcF2;
  assign dec_pc_A        = pca_q[hptr_q];
  assign dec_pc_B        = pcb_q[hptr_q];
  assign dec_instr_A     = ia_q[hptr_q];
  assign dec_instr_B     = ib_q[hptr_q];
  always_comb begin
    imem_req_valid = pc_valid & (occ_q != (PTR_W+1)'(DEPTH)) & ~flush & ~rst;
    accept         = imem_req_valid & imem_req_ready;
    pc_hold        = ~accept;
    dec_valid      = alloc_q[hptr_q] & filled_q[hptr_q] & ~rst;
    pop            = dec_valid & dec_ready & ~flush;
    fill           = imem_resp_valid & (drop_q == '0) & alloc_q[fptr_q] & ~flush;
    unfilled       = '0;
    for (int i = 0; i < DEPTH; i++) unfilled = unfilled + {{PTR_W{1'b0}}, alloc_q[i] & ~filled_q[i]};
    drop_sum = drop_q + unfilled;
    alloc_d  = alloc_q;
    filled_d = filled_q;
    pca_d    = pca_q;
    pcb_d    = pcb_q;
    ia_d     = ia_q;
    ib_d     = ib_q;
    aptr_d   = aptr_q;
    fptr_d   = fptr_q;
    hptr_d   = hptr_q;
    occ_d    = occ_q + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, pop};
    drop_d   = drop_q - {{PTR_W{1'b0}}, imem_resp_valid & (drop_q != '0)};
    if (flush) begin
      alloc_d  = '0;
      filled_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        pca_d[i] = '0;
        pcb_d[i] = '0;
        ia_d[i]  = '0;
        ib_d[i]  = '0;
      end
      aptr_d = '0;
      fptr_d = '0;
      hptr_d = '0;
      occ_d  = '0;
      // every unfilled request is still owed a response; the one landing now is already spent
      drop_d = drop_sum - {{PTR_W{1'b0}}, imem_resp_valid & (drop_sum != '0)};
    end else begin
      if (accept) begin
        alloc_d[aptr_q]  = 1'b1;
        filled_d[aptr_q] = 1'b0;
        pca_d[aptr_q]    = pcF1;
        pcb_d[aptr_q]    = pcF2;
        aptr_d           = aptr_q + PTR_W'(1);
      end
      if (fill) begin
        filled_d[fptr_q] = 1'b1;
        ia_d[fptr_q]     = imem_resp_instr_A;
        ib_d[fptr_q]     = imem_resp_instr_B;
        fptr_d           = fptr_q + PTR_W'(1);
      end
      if (pop) begin
        alloc_d[hptr_q]  = 1'b0;
        filled_d[hptr_q] = 1'b0;
        pca_d[hptr_q]    = '0;
        pcb_d[hptr_q]    = '0;
        ia_d[hptr_q]     = '0;
        ib_d[hptr_q]     = '0;
        hptr_d           = hptr_q + PTR_W'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q  <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pca_q[i] <= '0;
        pcb_q[i] <= '0;
        ia_q[i]  <= '0;
        ib_q[i]  <= '0;
      end
      aptr_q <= '0;
      fptr_q <= '0;
      hptr_q <= '0;
      occ_q  <= '0;
      drop_q <= '0;
    end else begin
      alloc_q  <= alloc_d;
      filled_q <= filled_d;
      pca_q    <= pca_d;
      pcb_q    <= pcb_d;
      ia_q     <= ia_d;
      ib_q     <= ib_d;
      aptr_q   <= aptr_d;
      fptr_q   <= fptr_d;
      hptr_q   <= hptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
    end
  end
  a_resp_alloc: assert property (@(posedge clk) disable iff (rst)
    (imem_resp_valid && drop_q == '0 && !flush) |-> alloc_q[fptr_q]);
endmodule

// File: tb/tb_fetch_pair_buffer.sv
// tb_fetch_pair_buffer: directed checks of fetch_pair_buffer against a latency-programmable memory model
module tb_fetch_pair_buffer;
  logic        clk = 0, rst = 1, pc_valid = 0, flush = 0, imem_req_ready = 1, dec_ready = 0;
  logic [31:0] pcF1 = 0, pcF2 = 0;
  logic        pc_hold, imem_req_valid, dec_valid;
  logic [31:0] imem_req_addr_A, imem_req_addr_B, dec_pc_A, dec_pc_B, dec_instr_A, dec_instr_B;
  logic        imem_resp_valid = 0;
  logic [31:0] imem_resp_instr_A = 0, imem_resp_instr_B = 0;
  int          checks = 0, errors = 0, lat = 1, ecnt = 0;

  fetch_pair_buffer dut (
    .clk(clk), .rst(rst), .pcF1(pcF1), .pcF2(pcF2), .pc_valid(pc_valid), .pc_hold(pc_hold),
    .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr_A(imem_req_addr_A), .imem_req_addr_B(imem_req_addr_B),
    .imem_resp_valid(imem_resp_valid), .imem_resp_instr_A(imem_resp_instr_A),
    .imem_resp_instr_B(imem_resp_instr_B), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc_A(dec_pc_A), .dec_pc_B(dec_pc_B), .dec_instr_A(dec_instr_A), .dec_instr_B(dec_instr_B)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] pc);
    return pc ^ 32'hA5A5_A5A5;
  endfunction

  // in-order memory: a request accepted in cycle c answers in cycle c+lat
  typedef struct { logic [31:0] a, b; int due; } req_t;
  req_t        mq[$];
  logic        hs_s = 0, rst_s = 1;
  logic [31:0] a_s = 0, b_s = 0;
  always @(negedge clk) begin
    hs_s  = imem_req_valid & imem_req_ready;
    rst_s = rst;
    a_s   = imem_req_addr_A;
    b_s   = imem_req_addr_B;
  end
  always @(posedge clk) begin
    ecnt = ecnt + 1;
    if (rst_s) begin
      mq.delete();
      imem_resp_valid <= 0;
    end else begin
      if (hs_s) mq.push_back('{a: a_s, b: b_s, due: ecnt + lat - 1});
      if (mq.size() > 0 && mq[0].due <= ecnt) begin
        imem_resp_valid   <= 1;
        imem_resp_instr_A <= f(mq[0].a);
        imem_resp_instr_B <= f(mq[0].b);
        void'(mq.pop_front());
      end else imem_resp_valid <= 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic pcs(input logic v, input logic [31:0] a);
    pc_valid = v;
    pcF1 = a;
    pcF2 = a + 4;
  endtask

  initial begin
    // reset
    pcs(1, 32'h10000);
    cyc(); cyc(); #1;
    chk("rst_hold", pc_hold, 1);
    chk("rst_req", imem_req_valid, 0);
    chk("rst_dv", dec_valid, 0);
    chk("rst_pc", dec_pc_A, 0);
    rst = 0; pc_valid = 0;
    // 1: streaming, L=1
    for (int i = 0; i < 9; i++) begin
      cyc(); pcs(i < 6, 32'h10000 + 8 * i); dec_ready = 1; #1;
      if (i < 6) chk("t1_hold", pc_hold, 0);
      if (i >= 2 && i < 8) begin
        chk("t1_dv", dec_valid, 1);
        chk("t1_pcA", dec_pc_A, 32'h10000 + 8 * (i - 2));
        chk("t1_pcB", dec_pc_B, 32'h10004 + 8 * (i - 2));
        chk("t1_inB", dec_instr_B, f(32'h10004 + 8 * (i - 2)));
      end else chk("t1_dv0", dec_valid, 0);
    end
    // 2: fill to DEPTH, then free one slot
    for (int i = 0; i < 5; i++) begin
      cyc(); pcs(1, 32'h30000 + 8 * i); dec_ready = 0; #1;
      chk("t2_hold", pc_hold, (i == 4) ? 1 : 0);
    end
    chk("t2_head", dec_pc_A, 32'h30000);
    cyc(); dec_ready = 1; #1;
    chk("t2_full_hold", pc_hold, 1);
    chk("t2_dv", dec_valid, 1);
    cyc(); dec_ready = 0; #1;
    chk("t2_acc5", pc_hold, 0);
    chk("t2_head2", dec_pc_A, 32'h30008);
    cyc(); pcs(1, 32'h30028); #1;
    chk("t2_full2", pc_hold, 1);
    pc_valid = 0;
    for (int j = 0; j < 4; j++) begin
      cyc(); dec_ready = 1; #1;
      chk("t2_drain_dv", dec_valid, 1);
      chk("t2_drain_pc", dec_pc_A, 32'h30008 + 8 * j);
      chk("t2_drain_in", dec_instr_A, f(32'h30008 + 8 * j));
    end
    cyc(); dec_ready = 0; #1;
    chk("t2_empty", dec_valid, 0);
    // 3: memory not ready
    for (int k = 0; k < 3; k++) begin
      cyc(); pcs(1, 32'h40000); imem_req_ready = 0; #1;
      chk("t3_hold", pc_hold, 1);
      chk("t3_req", imem_req_valid, 1);
      chk("t3_addrA", imem_req_addr_A, 32'h40000);
      chk("t3_addrB", imem_req_addr_B, 32'h40004);
    end
    pc_valid = 0; imem_req_ready = 1;
    cyc(); cyc(); cyc(); #1;
    chk("t3_noentry", dec_valid, 0);
    chk("t3_req0", imem_req_valid, 0);
    // 4: flush with one filled and two in flight, L=3
    lat = 3;
    cyc(); pcs(1, 32'h50000); #1;
    chk("t4_acc0", pc_hold, 0);
    cyc(); pc_valid = 0;
    cyc();
    cyc(); pcs(1, 32'h50008); #1;
    chk("t4_acc1", pc_hold, 0);
    cyc(); pcs(1, 32'h50010); #1;
    chk("t4_dv", dec_valid, 1);
    chk("t4_pc", dec_pc_A, 32'h50000);
    cyc(); pcs(1, 32'h20000); flush = 1; dec_ready = 1; #1;
    chk("t4_fl_req", imem_req_valid, 0);
    chk("t4_fl_hold", pc_hold, 1);
    cyc(); flush = 0; dec_ready = 0; #1;
    chk("t4_dv_after", dec_valid, 0);
    chk("t4_newacc", pc_hold, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); pc_valid = 0; #1;
      chk("t4_drop", dec_valid, 0);
    end
    cyc(); #1;
    chk("t4_new_dv", dec_valid, 1);
    chk("t4_new_pc", dec_pc_A, 32'h20000);
    chk("t4_new_inA", dec_instr_A, f(32'h20000));
    chk("t4_new_inB", dec_instr_B, f(32'h20004));
    dec_ready = 1;
    cyc(); dec_ready = 0; #1;
    chk("t4_popped", dec_valid, 0);
    // 5: flush coincident with a response, two unfilled
    cyc(); pcs(1, 32'h60000);
    cyc(); pcs(1, 32'h60008);
    cyc(); pc_valid = 0;
    cyc(); pcs(1, 32'h21000); flush = 1; #1;
    chk("t5_fl_req", imem_req_valid, 0);
    cyc(); flush = 0; #1;
    chk("t5_acc", pc_hold, 0);
    chk("t5_dv0", dec_valid, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); pc_valid = 0; #1;
      chk("t5_wait", dec_valid, 0);
    end
    cyc(); #1;
    chk("t5_dv", dec_valid, 1);
    chk("t5_pc", dec_pc_A, 32'h21000);
    chk("t5_in", dec_instr_A, f(32'h21000));
    dec_ready = 1;
    cyc(); dec_ready = 0; #1;
    chk("t5_popped", dec_valid, 0);
    // 6: reset mid-stream, L=1
    lat = 1;
    cyc(); pcs(1, 32'h70000);
    cyc(); pcs(1, 32'h70008);
    cyc(); pcs(1, 32'h70010); rst = 1; #1;
    chk("t6_rst_hold", pc_hold, 1);
    chk("t6_rst_req", imem_req_valid, 0);
    chk("t6_rst_dv", dec_valid, 0);
    cyc(); #1;
    chk("t6_dv", dec_valid, 0);
    chk("t6_pc", dec_pc_A, 0);
    chk("t6_in", dec_instr_A, 0);
    chk("t6_hold", pc_hold, 1);
    rst = 0; pc_valid = 0;
    cyc(); pcs(1, 32'h10000); dec_ready = 1; #1;
    chk("t6_acc", pc_hold, 0);
    cyc(); pc_valid = 0; #1;
    chk("t6_dv0", dec_valid, 0);
    cyc(); #1;
    chk("t6_dv1", dec_valid, 1);
    chk("t6_pcA", dec_pc_A, 32'h10000);
    chk("t6_inA", dec_instr_A, f(32'h10000));
    cyc(); #1;
    chk("t6_end", dec_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
